jtframe_db15_joy: RTL and testbench
===================================

# jtframe_db15_joy

Serial DB15 (SNAC) joystick reader feeding the `JOY_CLK`/`JOY_LOAD`/`JOY_DATA` pins of the MiSTer frame. It clocks a chain of 74HC165-style parallel-in/serial-out registers through the user port. It de-serialises and debounces one or two player frames. It presents active-high joystick words to the frame's input mux, which merges them with USB/HPS joysticks.

## Interface

Parameters:
- `CLK_DIV`, 8: `clk` cycles per serial tick; minimum 4, to cover the synchroniser delay.
- `FRAME_GAP`, 16: idle ticks between frames.
- `DEBOUNCE`, 1: when 1, outputs update only after two consecutive identical frames; when 0, every frame commits.

Ports:
- `clk` in 1: system clock (`clk_sys`).
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: reader enable. Driven from OSD `|status[31:30]`.
- `two_pl` in 1: 1 reads 24 bits (two players); 0 reads 12 bits. Driven from `status[31]`.
- `joy_data` in 1: serial data from `USER_IN[5]`. Asynchronous, active-low buttons.
- `joy_clk` out 1: shift clock to the pads. Rising edge shifts.
- `joy_load` out 1: parallel load. Low loads; idles high.
- `joy1` out 12: player 1. Bits: [3:0] right, left, down, up; [9:4] B1–B6; [10] start; [11] coin. Active high.
- `joy2` out 12: player 2, same layout. Held 0 when `two_pl`=0.
- `frame_done` out 1: one-cycle pulse when a frame finishes shifting.

## Operation

- `joy_data` passes through a two-flop synchroniser. The synchronised value is `sd`.
- Tick counter: `div` counts 0..CLK_DIV-1 and wraps. `tick` is asserted when `div`==CLK_DIV-1. All FSM transitions happen on `tick` only.
- `NBITS` = `two_pl` ? 24 : 12. `two_pl` is latched at entry to LOAD and held constant for the whole frame.
- FSM states:
  - IDLE: `joy_load`=1, `joy_clk`=0. Goes to LOAD on the first tick with `en`=1.
  - LOAD: `joy_load`=0 for one tick; clears `bit_cnt` and the shift register. Goes to LOW.
  - LOW: `joy_clk`=0. On tick, capture `~sd` into `shreg[bit_cnt]`. Goes to HIGH.
  - HIGH: `joy_clk`=1. On tick: if `bit_cnt`==NBITS-1, commit and go to GAP; otherwise increment `bit_cnt` and go to LOW.
  - GAP: `joy_load`=1, `joy_clk`=0 for FRAME_GAP ticks. Then goes to LOAD.
- Bit order: serial bit k (k=0 is the first bit captured after load) maps to `{joy2,joy1}[k]`.
- Commit rules:
  - `frame_done`=1 for exactly one cycle on every commit.
  - `last_frame` is always updated to the new frame.
  - If DEBOUNCE=0, or the new frame equals `last_frame`, `joy1`/`joy2` take the new frame.
  - When `two_pl`=0, `joy2` is forced to 0.
- `en` falling, in any state: on the next cycle (not the next tick) the FSM goes to IDLE, `joy_clk`=0 and `joy_load`=1. The partial frame is discarded. `joy1`, `joy2` and `last_frame` clear to 0, and `div` resets.

## Timing

- Reset values:
  - `joy_clk`=0, `joy_load`=1, `joy1`=`joy2`=0, `frame_done`=0.
  - State = IDLE, `div`=0, `last_frame`=0.
- Pin outputs are registered and change only on the cycle after `tick`. The exception is the immediate response to `en` low.
- Frame period: (1 + 2·NBITS + FRAME_GAP) ticks.
  - 24-bit frame: 65 ticks = 520 `clk` at defaults.
  - 12-bit frame: 41 ticks.
- `frame_done` and the output update occur in the same cycle, one cycle after the final HIGH tick.
- Latency from a pad change to the outputs: at most 2 frames plus 2 sync cycles with DEBOUNCE=1, and at most 1 frame plus 2 sync cycles with DEBOUNCE=0.
- The sample point is the last cycle of the LOW half. Data therefore has CLK_DIV-1 cycles to settle after the shift edge, which covers the 2-cycle synchroniser.

## Structure

- Package `jtframe_db15_pkg` holds:
  - the state enum `db15_st_t` (IDLE, LOAD, LOW, HIGH, GAP);
  - localparams for the bit positions (`JOY_RIGHT`=0 … `JOY_COIN`=11) and `DB15_BITS`=12.
- No sub-module. The synchroniser, tick divider and FSM live in one file.
- The instance sits in the frame top-level. `joy_clk`/`joy_load` drive `USER_OUT[1:0]`.

## Test plan

- Reset, then `en`=0 for 1000 cycles → `joy_load`=1, `joy_clk`=0, outputs 0, no `frame_done`.
- `en`=1, `two_pl`=1, CLK_DIV=4, DEBOUNCE=0, pad model serialising active-low 24'h5A3C81 inverted → after the first `frame_done`, {`joy2`,`joy1`}=24'h5A3C81. Period between pulses is 260 cycles. `joy_clk` shows 24 rising edges per frame.
- `two_pl`=0 with the same model → 12 `joy_clk` edges per frame, `joy1`=12'hC81, `joy2`=0, period 164 cycles.
- DEBOUNCE=1, pad alternates 12'h001/12'h002 every frame → outputs stay 0. Pad then holds 12'h001 → `joy1`=12'h001 at the second matching `frame_done`.
- Drop `en` during bit 7 → next cycle `joy_clk`=0, `joy_load`=1, outputs 0, no `frame_done`. Re-enable → a full frame starts with LOAD.
- Assert `rst_n`=0 asynchronously mid-HIGH → outputs at their reset values with no `clk` edge required. Operation resumes cleanly after release.

Source files
------------

// File: rtl/jtframe_db15_pkg.sv
// Shared types and bit positions for the DB15 (SNAC) serial joystick reader.
package jtframe_db15_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOW,
        HIGH,
        GAP
    } db15_st_t;

    localparam int DB15_BITS = 12;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_B1    = 4;
    localparam int JOY_B2    = 5;
    localparam int JOY_B3    = 6;
    localparam int JOY_B4    = 7;
    localparam int JOY_B5    = 8;
    localparam int JOY_B6    = 9;
    localparam int JOY_START = 10;
    localparam int JOY_COIN  = 11;

endpackage

// File: rtl/jtframe_db15_joy.sv
// DB15 serial joystick reader: shifts a 74HC165 chain through the user port,
// de-serialises one or two player frames and optionally debounces them.
//
// state | meaning
// IDLE  | reader disabled, load high, shift clock low
// LOAD  | load pulse low for one tick; two_pl latched, frame cleared
// LOW   | shift clock low; data sampled on the last cycle of the half
// HIGH  | shift clock high; rising edge advances the pad chain
// GAP   | idle ticks between frames
module jtframe_db15_joy
    import jtframe_db15_pkg::*;
#(
    parameter int CLK_DIV   = 8,
    parameter int FRAME_GAP = 16,
    parameter int DEBOUNCE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 two_pl,
    input  logic                 joy_data,
    output logic                 joy_clk,
    output logic                 joy_load,
    output logic [DB15_BITS-1:0] joy1,
    output logic [DB15_BITS-1:0] joy2,
    output logic                 frame_done
);

    localparam int FW = 2 * DB15_BITS;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(FRAME_GAP - 1);

    db15_st_t      state, state_nx;
    logic [DW-1:0] div;
    logic          tick;
    logic [1:0]    sync;
    logic          sd;
    logic [4:0]    bit_cnt, bit_cnt_nx;
    logic [4:0]    last_bit;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic [FW-1:0] shreg, shreg_nx;
    logic [FW-1:0] last_frame, last_nx;
    logic [FW-1:0] joy_nx;
    logic          pl2, pl2_nx;
    logic          done_nx;

    assign sd       = sync[1];
    assign tick     = (div == DIV_LAST);
    assign last_bit = pl2 ? 5'(FW - 1) : 5'(DB15_BITS - 1);

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        gap_nx     = gap_cnt;
        shreg_nx   = shreg;
        last_nx    = last_frame;
        joy_nx     = {joy2, joy1};
        pl2_nx     = pl2;
        done_nx    = 1'b0;

        if (!en) begin
            // disabling discards everything, including the debounce history
            state_nx = IDLE;
            last_nx  = '0;
            joy_nx   = '0;
        end else if (tick) begin
            case (state)
                IDLE: state_nx = LOAD;
                LOAD: state_nx = LOW;
                LOW: begin
                    shreg_nx[bit_cnt] = ~sd;
                    state_nx          = HIGH;
                end
                HIGH: begin
                    if (bit_cnt == last_bit) begin
                        state_nx = GAP;
                        gap_nx   = GAP_INIT;
                        done_nx  = 1'b1;
                        last_nx  = shreg;
                        if (DEBOUNCE == 0 || shreg == last_frame)
                            joy_nx = pl2 ? shreg : {{DB15_BITS{1'b0}}, shreg[DB15_BITS-1:0]};
                    end else begin
                        bit_cnt_nx = bit_cnt + 5'd1;
                        state_nx   = LOW;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state_nx = LOAD;
                    else               gap_nx   = gap_cnt - 1'b1;
                end
                default: state_nx = IDLE;
            endcase

            if (state_nx == LOAD && state != LOAD) begin
                pl2_nx     = two_pl;
                bit_cnt_nx = '0;
                shreg_nx   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div        <= '0;
            sync       <= 2'b11;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            last_frame <= '0;
            pl2        <= 1'b0;
            joy_clk    <= 1'b0;
            joy_load   <= 1'b1;
            joy1       <= '0;
            joy2       <= '0;
            frame_done <= 1'b0;
        end else begin
            state        <= state_nx;
            div          <= (!en || tick) ? '0 : div + 1'b1;
            sync         <= {sync[0], joy_data};
            bit_cnt      <= bit_cnt_nx;
            gap_cnt      <= gap_nx;
            shreg        <= shreg_nx;
            last_frame   <= last_nx;
            pl2          <= pl2_nx;
            joy_clk      <= (state_nx == HIGH);
            joy_load     <= (state_nx != LOAD);
            {joy2, joy1} <= joy_nx;
            frame_done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_jtframe_db15_joy.sv
// Bench for jtframe_db15_joy: a raw and a debounced instance read the same
// pad pattern through 74HC165-like chain models.
module tb_jtframe_db15_joy;

    localparam int CLK_DIV   = 4;
    localparam int FRAME_GAP = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        two_pl;
    logic        raw_data, deb_data;
    logic        raw_jclk, raw_jload, deb_jclk, deb_jload;
    logic [11:0] raw_j1, raw_j2, deb_j1, deb_j2;
    logic        raw_done, deb_done;

    logic [23:0] pad = 24'h0;
    logic [23:0] sr_raw = '1;
    logic [23:0] sr_deb = '1;

    int cyc = 0;
    int edges = 0;
    int done_cnt = 0;
    int checks = 0;
    int passed = 0;
    int last_done_cyc = 0;
    int period = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(posedge clk) if (raw_done) done_cnt++;
    always @(posedge raw_jclk) edges++;

    // chain model: low load captures the active-low pads, rising clock shifts toward Q7
    always @(posedge raw_jclk or negedge raw_jload)
        if (!raw_jload) sr_raw <= ~pad;
        else            sr_raw <= {1'b1, sr_raw[23:1]};
    always @(posedge deb_jclk or negedge deb_jload)
        if (!deb_jload) sr_deb <= ~pad;
        else            sr_deb <= {1'b1, sr_deb[23:1]};

    assign raw_data = sr_raw[0];
    assign deb_data = sr_deb[0];

    jtframe_db15_joy #(.CLK_DIV(CLK_DIV), .FRAME_GAP(FRAME_GAP), .DEBOUNCE(0)) u_raw (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .two_pl     (two_pl),
        .joy_data   (raw_data),
        .joy_clk    (raw_jclk),
        .joy_load   (raw_jload),
        .joy1       (raw_j1),
        .joy2       (raw_j2),
        .frame_done (raw_done)
    );

    jtframe_db15_joy #(.CLK_DIV(CLK_DIV), .FRAME_GAP(FRAME_GAP), .DEBOUNCE(1)) u_deb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .two_pl     (two_pl),
        .joy_data   (deb_data),
        .joy_clk    (deb_jclk),
        .joy_load   (deb_jload),
        .joy1       (deb_j1),
        .joy2       (deb_j2),
        .frame_done (deb_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!raw_done && n < 800);
        check({tag, "_seen"}, 32'(raw_done), 32'd1);
        check({tag, "_both"}, 32'(deb_done), 32'd1);
        period        = cyc - last_done_cyc;
        last_done_cyc = cyc;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_jclk"},  32'(raw_jclk),  32'd0);
        check({tag, "_jload"}, 32'(raw_jload), 32'd1);
        check({tag, "_joy"},   32'({raw_j2, raw_j1}), 32'd0);
        check({tag, "_done"},  32'(raw_done),  32'd0);
        check({tag, "_djoy"},  32'({deb_j2, deb_j1}), 32'd0);
    endtask

    initial begin
        int          mark;
        int          dc;
        int          n;
        logic [23:0] fr, prev, dexp;
        logic [11:0] pats [6];
        logic [11:0] dpat [6];

        rst_n  = 1'b0;
        en     = 1'b0;
        two_pl = 1'b1;
        pad    = 24'h0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;

        repeat (1000) @(negedge clk);
        check_quiet("idle");
        check("idle_no_done",  32'(done_cnt), 32'd0);
        check("idle_no_edges", 32'(edges),    32'd0);

        // two players, raw and debounced
        pad  = 24'h5A3C81;
        en   = 1'b1;
        mark = edges;
        wait_done("f24_a");
        check("f24_a_raw",   32'({raw_j2, raw_j1}), 32'h5A3C81);
        check("f24_a_deb",   32'({deb_j2, deb_j1}), 32'h0);
        check("f24_a_edges", 32'(edges - mark), 32'd24);
        mark = edges;
        wait_done("f24_b");
        check("f24_period",  32'(period), 32'd260);
        check("f24_b_edges", 32'(edges - mark), 32'd24);
        check("f24_b_raw",   32'({raw_j2, raw_j1}), 32'h5A3C81);
        check("f24_b_deb",   32'({deb_j2, deb_j1}), 32'h5A3C81);

        // one player
        two_pl = 1'b0;
        mark   = edges;
        wait_done("f12_a");
        check("f12_a_j1",    32'(raw_j1), 32'hC81);
        check("f12_a_j2",    32'(raw_j2), 32'h0);
        check("f12_a_edges", 32'(edges - mark), 32'd12);
        mark = edges;
        wait_done("f12_b");
        check("f12_period",  32'(period), 32'd164);
        check("f12_b_edges", 32'(edges - mark), 32'd12);
        check("f12_b_deb",   32'({deb_j2, deb_j1}), 32'h000C81);

        // debounce against an alternating pad
        en = 1'b0;
        @(negedge clk);
        check("dis_clear_deb", 32'({deb_j2, deb_j1}), 32'h0);
        check("dis_clear_raw", 32'({raw_j2, raw_j1}), 32'h0);
        pats = '{12'h001, 12'h002, 12'h001, 12'h002, 12'h001, 12'h001};
        dpat = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h001};
        pad  = 24'h001;
        en   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pad = {12'h0, pats[i]};
            wait_done("alt");
            check("alt_raw", 32'(raw_j1), 32'(pats[i]));
            check("alt_deb", 32'(deb_j1), 32'(dpat[i]));
        end

        // random frames against the reference model, both widths
        for (int mode = 1; mode >= 0; mode--) begin
            en     = 1'b0;
            two_pl = mode[0];
            @(negedge clk);
            prev = 24'h0;
            dexp = 24'h0;
            en   = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (i == 0 || $urandom_range(1) == 0) pad = 24'($urandom);
                fr = mode[0] ? pad : {12'h0, pad[11:0]};
                wait_done("rnd");
                check("rnd_raw", 32'({raw_j2, raw_j1}), 32'(fr));
                if (fr == prev) dexp = fr;
                prev = fr;
                check("rnd_deb", 32'({deb_j2, deb_j1}), 32'(dexp));
            end
        end

        // drop enable in the middle of bit 7 (one-player mode)
        pad = 24'hABC123;
        wait_done("pre_drop");
        check("pre_drop_raw", 32'(raw_j1), 32'h123);
        mark = edges;
        n    = 0;
        while (edges - mark < 7 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drop_reach_bit7", 32'(edges - mark), 32'd7);
        repeat (5) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check_quiet("drop");
        dc = done_cnt;
        repeat (300) @(negedge clk);
        check("drop_no_done",  32'(done_cnt), 32'(dc));
        check("drop_no_edges", 32'(edges - mark), 32'd7);

        en   = 1'b1;
        mark = edges;
        n    = 0;
        while (raw_jload && n < 3 * CLK_DIV) begin
            @(negedge clk);
            n++;
        end
        check("reen_load",       32'(raw_jload), 32'd0);
        check("reen_load_first", 32'(edges - mark), 32'd0);
        wait_done("reen");
        check("reen_raw",   32'(raw_j1), 32'h123);
        check("reen_edges", 32'(edges - mark), 32'd12);

        // asynchronous reset while the shift clock is high
        n = 0;
        while (!raw_jclk && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_in_high", 32'(raw_jclk), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_quiet("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_done("post_rst_a");
        check("post_rst_a_raw", 32'({raw_j2, raw_j1}), 32'h000123);
        check("post_rst_a_deb", 32'({deb_j2, deb_j1}), 32'h0);
        wait_done("post_rst_b");
        check("post_rst_period", 32'(period), 32'd164);
        check("post_rst_b_deb",  32'({deb_j2, deb_j1}), 32'h000123);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
